// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the packet-granular round-robin stream arbiter.
package stream_arb_pkg;

   localparam int MAX_PORTS   = 16;
   localparam int MAX_ID_W    = 4;
   localparam int PKT_COUNT_W = 16;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic                found;
      logic [MAX_ID_W-1:0] index;
   } rr_result_t;

   // Scan the valid vector starting at ptr, wrapping at numPorts; first hit wins.
   function automatic rr_result_t rr_next_grant(
      input logic [MAX_PORTS-1:0] validVec,
      input logic [MAX_ID_W-1:0]  ptr,
      input int unsigned          numPorts
   );
      rr_result_t  result;
      int unsigned cand;
      result.found = 1'b0;
      result.index = '0;
      for (int unsigned i = 0; i < MAX_PORTS; i++) begin
         cand = {28'd0, ptr} + i;
         if (cand >= numPorts) begin
            cand = cand - numPorts;
         end
         if (!result.found && (i < numPorts) && validVec[cand[MAX_ID_W-1:0]]) begin
            result.found = 1'b1;
            result.index = cand[MAX_ID_W-1:0];
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/stream_skid.sv
// Two-register skid stage: an output register plus a skid register. Upstream
// ready is simply "skid register empty", so it comes straight from a flop.
module stream_skid #(
   parameter int DW = 17
)(
   input  logic          i_clock,
   input  logic          i_reset,
   input  logic          i_valid,
   output logic          o_ready,
   input  logic [DW-1:0] i_data,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [DW-1:0] o_data
);

   logic          r_outValid;
   logic [DW-1:0] r_outData;
   logic          r_skidValid;
   logic [DW-1:0] r_skidData;

   // Move beats into the output register, parking one in the skid register when downstream stalls
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_outValid  <= 1'b0;
         r_outData   <= '0;
         r_skidValid <= 1'b0;
         r_skidData  <= '0;
      end else if (!r_skidValid) begin
         if (i_valid) begin
            if (!r_outValid || i_ready) begin
               r_outValid <= 1'b1;
               r_outData  <= i_data;
            end else begin
               r_skidValid <= 1'b1;
               r_skidData  <= i_data;
            end
         end else if (i_ready) begin
            r_outValid <= 1'b0;
         end
      end else if (i_ready) begin
         r_outData   <= r_skidData;
         r_skidValid <= 1'b0;
      end
   end

   assign o_ready = !r_skidValid;
   assign o_valid = r_outValid;
   assign o_data  = r_outData;

endmodule

// File: rtl/stream_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one registered stream between
// NUM_PORTS requesters. A grant is held until the granted port's last beat is
// accepted. Optional per-port packet counters: define STREAM_RR_ARBITER_PKT_COUNT_EN.
module stream_rr_arbiter
   import stream_arb_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int NUM_PORTS = 4,
   parameter int ID_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
)(
   input  logic                       i_clock,
   input  logic                       i_reset,
   input  logic [NUM_PORTS*WIDTH-1:0] i_in_data,
   input  logic [NUM_PORTS-1:0]       i_in_valid,
   input  logic [NUM_PORTS-1:0]       i_in_last,
   output logic [NUM_PORTS-1:0]       o_in_ready,
   output logic [WIDTH-1:0]           o_out_data,
   output logic                       o_out_last,
   output logic                       o_out_valid,
   input  logic                       i_out_ready,
   output logic [ID_W-1:0]            o_grant_id,
   output logic                       o_busy
`ifdef STREAM_RR_ARBITER_PKT_COUNT_EN
   ,
   output logic [NUM_PORTS*PKT_COUNT_W-1:0] o_pkt_count
`endif
);

   arb_state_t           r_state;
   logic [ID_W-1:0]      r_grantId;
   logic [ID_W-1:0]      r_ptr;
   logic                 r_busy;

   logic [MAX_PORTS-1:0] w_validPad;
   logic [MAX_ID_W-1:0]  w_ptrPad;
   rr_result_t           w_search;
   logic [ID_W-1:0]      w_searchIdx;
   logic [ID_W-1:0]      w_ptrNext;
   logic [WIDTH-1:0]     w_selData;
   logic                 w_selLast;
   logic                 w_selValid;
   logic                 w_skidReady;
   logic                 w_skidInValid;
   logic                 w_fire;
   logic [WIDTH:0]       w_skidOut;

   // Widen valid vector and pointer to the fixed width the search helper expects
   always_comb begin
      w_validPad                  = '0;
      w_validPad[NUM_PORTS-1:0]   = i_in_valid;
      w_ptrPad                    = '0;
      w_ptrPad[ID_W-1:0]          = r_ptr;
   end

   assign w_search = rr_next_grant(w_validPad, w_ptrPad, NUM_PORTS);

   // Narrow the search result back to a legal grant index
   always_comb begin
      w_searchIdx = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (w_search.index == k[MAX_ID_W-1:0]) begin
            w_searchIdx = k[ID_W-1:0];
         end
      end
   end

   assign w_ptrNext = (r_grantId == ID_W'(NUM_PORTS - 1)) ? '0 : r_grantId + ID_W'(1);

   // Forward the granted port's valid/data/last toward the skid stage
   always_comb begin
      w_selData  = '0;
      w_selLast  = 1'b0;
      w_selValid = 1'b0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (r_grantId == k[ID_W-1:0]) begin
            w_selData  = i_in_data[k*WIDTH +: WIDTH];
            w_selLast  = i_in_last[k];
            w_selValid = i_in_valid[k];
         end
      end
   end

   // Only the granted port sees ready, and only while a packet is locked
   always_comb begin
      o_in_ready = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if ((r_state == ARB_LOCKED) && (r_grantId == k[ID_W-1:0])) begin
            o_in_ready[k] = w_skidReady;
         end
      end
   end

   assign w_skidInValid = (r_state == ARB_LOCKED) && w_selValid;
   assign w_fire        = w_skidInValid && w_skidReady;

   // Grant on a found requester, hold the lock until the last beat is accepted, then rotate
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state   <= ARB_IDLE;
         r_grantId <= '0;
         r_ptr     <= '0;
         r_busy    <= 1'b0;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (w_search.found) begin
                  r_grantId <= w_searchIdx;
                  r_state   <= ARB_LOCKED;
                  r_busy    <= 1'b1;
               end
            end
            ARB_LOCKED: begin
               if (w_fire && w_selLast) begin
                  r_state <= ARB_IDLE;
                  r_busy  <= 1'b0;
                  r_ptr   <= w_ptrNext;
               end
            end
         endcase
      end
   end

   stream_skid #(
      .DW (WIDTH + 1)
   ) u_skid (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_valid (w_skidInValid),
      .o_ready (w_skidReady),
      .i_data  ({w_selLast, w_selData}),
      .o_valid (o_out_valid),
      .i_ready (i_out_ready),
      .o_data  (w_skidOut)
   );

   assign o_out_data = w_skidOut[WIDTH-1:0];
   assign o_out_last = w_skidOut[WIDTH];
   assign o_grant_id = r_grantId;
   assign o_busy     = r_busy;

`ifdef STREAM_RR_ARBITER_PKT_COUNT_EN
   logic [NUM_PORTS*PKT_COUNT_W-1:0] r_pktCount;

   // Count completed packets per port as their last beat enters the skid stage
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_pktCount <= '0;
      end else if (w_fire && w_selLast) begin
         for (int k = 0; k < NUM_PORTS; k++) begin
            if (r_grantId == k[ID_W-1:0]) begin
               r_pktCount[k*PKT_COUNT_W +: PKT_COUNT_W] <=
                  r_pktCount[k*PKT_COUNT_W +: PKT_COUNT_W] + PKT_COUNT_W'(1);
            end
         end
      end
   end

   assign o_pkt_count = r_pktCount;
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter: per-port source queues driven by
// handshake, a scoreboard of expected output beats, and directed scenarios.
module tb_stream_rr_arbiter;

   localparam int WIDTH     = 16;
   localparam int NUM_PORTS = 4;
   localparam int ID_W      = 2;
   localparam int MEM_DEPTH = 256;

   logic                       i_clock = 1'b0;
   logic                       i_reset = 1'b1;
   logic [NUM_PORTS*WIDTH-1:0] i_in_data = '0;
   logic [NUM_PORTS-1:0]       i_in_valid = '0;
   logic [NUM_PORTS-1:0]       i_in_last = '0;
   logic [NUM_PORTS-1:0]       o_in_ready;
   logic [WIDTH-1:0]           o_out_data;
   logic                       o_out_last;
   logic                       o_out_valid;
   logic                       i_out_ready = 1'b1;
   logic [ID_W-1:0]            o_grant_id;
   logic                       o_busy;
`ifdef STREAM_RR_ARBITER_PKT_COUNT_EN
   logic [NUM_PORTS*16-1:0]    o_pkt_count;
`endif

   stream_rr_arbiter #(
      .WIDTH     (WIDTH),
      .NUM_PORTS (NUM_PORTS)
   ) dut (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_in_data   (i_in_data),
      .i_in_valid  (i_in_valid),
      .i_in_last   (i_in_last),
      .o_in_ready  (o_in_ready),
      .o_out_data  (o_out_data),
      .o_out_last  (o_out_last),
      .o_out_valid (o_out_valid),
      .i_out_ready (i_out_ready),
      .o_grant_id  (o_grant_id),
      .o_busy      (o_busy)
`ifdef STREAM_RR_ARBITER_PKT_COUNT_EN
      ,
      .o_pkt_count (o_pkt_count)
`endif
   );

   always #5 i_clock = ~i_clock;

   int checks = 0;
   int errors = 0;

   logic [WIDTH:0]       srcMem [NUM_PORTS][MEM_DEPTH];
   int                   srcHead [NUM_PORTS] = '{default: 0};
   int                   srcTail [NUM_PORTS] = '{default: 0};
   logic [NUM_PORTS-1:0] srcHold = '0;
   logic [NUM_PORTS-1:0] srcFirst = '1;
   logic [NUM_PORTS-1:0] fireSnap = '0;
   logic                 resetSnap = 1'b1;
   logic [WIDTH:0]       sbQ [$];
   bit                   monOn = 1'b0;
   bit                   bubbleOn = 1'b0;
   int                   cycleCount = 0;
   int                   lastEndCycle = -1;

   // Count and report one comparison
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Queue one packet of nBeats incrementing words on a source port
   task automatic applyStimulus(input int port, input int nBeats, input int base);
      logic [WIDTH-1:0] d;
      for (int b = 0; b < nBeats; b++) begin
         d = WIDTH'(base + b);
         srcMem[port][srcTail[port]] = {(b == nBeats - 1), d};
         srcTail[port]++;
      end
   endtask

   // Push the beats of one packet onto the output scoreboard
   task automatic expectPacket(input int nBeats, input int base);
      logic [WIDTH-1:0] d;
      for (int b = 0; b < nBeats; b++) begin
         d = WIDTH'(base + b);
         sbQ.push_back({(b == nBeats - 1), d});
      end
   endtask

   // Drive port inputs from the head of each source queue
   task automatic refreshInputs();
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (srcHead[k] < srcTail[k]) begin
            i_in_valid[k]                 = !srcHold[k];
            i_in_data[k*WIDTH +: WIDTH]   = srcMem[k][srcHead[k]][WIDTH-1:0];
            i_in_last[k]                  = srcMem[k][srcHead[k]][WIDTH];
         end else begin
            i_in_valid[k]                 = 1'b0;
            i_in_data[k*WIDTH +: WIDTH]   = '0;
            i_in_last[k]                  = 1'b0;
         end
      end
   endtask

   // Source driver: advance accepted beats and check the one-cycle arbitration bubble
   always @(posedge i_clock) begin
      fireSnap  = i_in_valid & o_in_ready & {NUM_PORTS{~i_reset}};
      resetSnap = i_reset;
      cycleCount++;
      #1;
      if (!bubbleOn) lastEndCycle = -1;
      if (resetSnap) srcFirst = '1;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (fireSnap[k]) begin
            if (srcFirst[k] && bubbleOn && (lastEndCycle >= 0)) begin
               checkOutput("pkt_bubble", 32'(cycleCount - lastEndCycle), 32'd2);
            end
            if (srcMem[k][srcHead[k]][WIDTH]) begin
               lastEndCycle = cycleCount;
               srcFirst[k]  = 1'b1;
            end else begin
               srcFirst[k]  = 1'b0;
            end
            srcHead[k]++;
         end
      end
      refreshInputs();
   end

   // Output monitor: every downstream transfer must match the scoreboard head
   always @(negedge i_clock) begin
      logic [WIDTH:0] expBeat;
      if (monOn && !i_reset && o_out_valid && i_out_ready) begin
         if (sbQ.size() > 0) expBeat = sbQ.pop_front();
         else expBeat = '1;
         checkOutput("out_beat", 32'({o_out_last, o_out_data}), 32'(expBeat));
      end
   end

   task automatic waitDrain(input string tag, input int budget);
      for (int c = 0; c < budget && sbQ.size() != 0; c++) @(negedge i_clock);
      checkOutput(tag, 32'(sbQ.size()), 32'd0);
      repeat (2) @(negedge i_clock);
   endtask

   task automatic waitBusy(input string tag, input int budget);
      for (int c = 0; c < budget && !o_busy; c++) @(negedge i_clock);
      checkOutput(tag, 32'(o_busy), 32'd1);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      i_reset     = 1'b1;
      i_out_ready = 1'b1;
      repeat (3) @(negedge i_clock);
      checkOutput("rst_out_valid", 32'(o_out_valid), 32'd0);
      checkOutput("rst_out_data",  32'(o_out_data),  32'd0);
      checkOutput("rst_out_last",  32'(o_out_last),  32'd0);
      checkOutput("rst_in_ready",  32'(o_in_ready),  32'd0);
      checkOutput("rst_grant_id",  32'(o_grant_id),  32'd0);
      checkOutput("rst_busy",      32'(o_busy),      32'd0);
      i_reset = 1'b0;

      $display("[TB] idle");
      for (int c = 0; c < 100; c++) begin
         @(negedge i_clock);
         checkOutput("idle", 32'({o_out_valid, o_busy, o_in_ready}), 32'd0);
      end
      monOn = 1'b1;

      $display("[TB] round-robin fairness");
      bubbleOn = 1'b1;
      for (int pkt = 0; pkt < 2; pkt++) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            applyStimulus(p, 3, p * 256);
            expectPacket(3, p * 256);
         end
      end
      waitDrain("fair_drain", 200);
      bubbleOn = 1'b0;

      $display("[TB] gap and skip");
      applyStimulus(1, 4, 'h0100);
      applyStimulus(3, 2, 'h0300);
      expectPacket(4, 'h0100);
      expectPacket(2, 'h0300);
      waitBusy("gap_busy", 20);
      checkOutput("gap_grant1", 32'(o_grant_id), 32'd1);
      for (int c = 0; c < 50 && srcHead[1] < 2; c++) @(negedge i_clock);
      srcHold[1] = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge i_clock);
         checkOutput("gap_hold", 32'({o_busy, o_grant_id, o_in_ready[3]}), 32'b1010);
      end
      srcHold[1] = 1'b0;
      for (int c = 0; c < 50 && o_busy; c++) @(negedge i_clock);
      @(negedge i_clock);
      checkOutput("skip_grant3", 32'({o_busy, o_grant_id}), 32'b111);
      waitDrain("gap_drain", 100);

      $display("[TB] backpressure");
      applyStimulus(2, 16, 0);
      expectPacket(16, 0);
      waitBusy("bp_busy", 20);
      checkOutput("bp_grant2", 32'(o_grant_id), 32'd2);
      for (int c = 0; c < 400 && sbQ.size() != 0; c++) begin
         @(posedge i_clock);
         #2;
         i_out_ready = (c < 40) ? ((c % 5) < 2) : (((c - 40) % 9) < 4);
      end
      i_out_ready = 1'b1;
      @(negedge i_clock);
      checkOutput("bp_drain", 32'(sbQ.size()), 32'd0);
      repeat (2) @(negedge i_clock);

      $display("[TB] reset mid-packet");
      monOn = 1'b0;
      applyStimulus(1, 5, 'h0A00);
      for (int c = 0; c < 50 && srcHead[1] < 2; c++) @(negedge i_clock);
      i_reset = 1'b1;
      for (int k = 0; k < NUM_PORTS; k++) srcTail[k] = srcHead[k];
      sbQ.delete();
      @(negedge i_clock);
      checkOutput("rstmid_valid", 32'(o_out_valid), 32'd0);
      checkOutput("rstmid_grant", 32'(o_grant_id), 32'd0);
      checkOutput("rstmid_busy_ready", 32'({o_busy, o_in_ready}), 32'd0);
      checkOutput("rstmid_data", 32'({o_out_last, o_out_data}), 32'd0);
      i_reset = 1'b0;
      monOn = 1'b1;
      applyStimulus(0, 3, 'h0B00);
      applyStimulus(3, 2, 'h0C00);
      expectPacket(3, 'h0B00);
      expectPacket(2, 'h0C00);
      waitBusy("rstmid_busy", 20);
      checkOutput("rstmid_first_grant", 32'(o_grant_id), 32'd0);
      waitDrain("rstmid_drain", 100);

      $display("[TB] single-beat packets");
      i_reset = 1'b1;
      @(negedge i_clock);
      i_reset = 1'b0;
      bubbleOn = 1'b1;
      for (int p = 0; p < 7; p++) applyStimulus(0, 1, 'h0D00 + p);
      for (int p = 0; p < 2; p++) applyStimulus(3, 1, 'h0E00 + p);
      expectPacket(1, 'h0D00);
      expectPacket(1, 'h0E00);
      expectPacket(1, 'h0D01);
      expectPacket(1, 'h0E01);
      for (int p = 2; p < 7; p++) expectPacket(1, 'h0D00 + p);
      waitDrain("single_drain", 200);
      bubbleOn = 1'b0;
`ifdef STREAM_RR_ARBITER_PKT_COUNT_EN
      checkOutput("pkt_count0", 32'(o_pkt_count[0*16 +: 16]), 32'd7);
      checkOutput("pkt_count1", 32'(o_pkt_count[1*16 +: 16]), 32'd0);
      checkOutput("pkt_count2", 32'(o_pkt_count[2*16 +: 16]), 32'd0);
      checkOutput("pkt_count3", 32'(o_pkt_count[3*16 +: 16]), 32'd2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Shares one skid-buffered valid/ready stream between NUM_PORTS upstream requesters.
- Arbitration is packet-granular round-robin: a grant is held until the granted port's last beat is accepted, then rotates.
- Output is fully registered through an internal skid stage, so downstream sees registered valid/data/last and upstream ready is registered-timing friendly.
- Sits in front of shared datapath consumers (e.g. a single DMA or serializer lane).

Parameters:
- WIDTH, 16, data bits per beat.
- NUM_PORTS, 4, number of requesters; legal range 1..16.
- ID_W, $clog2(NUM_PORTS) (minimum 1), width of the grant index.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_in_data  in  NUM_PORTS*WIDTH  per-port data; port k occupies bits [k*WIDTH +: WIDTH].
- i_in_valid  in  NUM_PORTS  per-port valid.
- i_in_last  in  NUM_PORTS  per-port end-of-packet flag.
- o_in_ready  out  NUM_PORTS  per-port ready.
- o_out_data  out  WIDTH  output data.
- o_out_last  out  1  output end-of-packet.
- o_out_valid  out  1  output valid.
- i_out_ready  in  1  downstream ready.
- o_grant_id  out  ID_W  index of the currently or last granted port.
- o_busy  out  1  high while LOCKED.

Behaviour:
- Interface: reset i_reset, synchronous, active-high; clock i_clock.
- Reset values: o_out_valid=0, o_out_data=0, o_out_last=0, o_in_ready=0, o_grant_id=0, o_busy=0; rr pointer=0; skid stage empty.
- Transfer: a beat transfers on a rising edge when valid&ready are both high. Valid must not depend on ready.
- FSM IDLE:
  - Searches i_in_valid starting at the rr pointer, wrapping modulo NUM_PORTS.
  - The first set bit becomes the grant; o_grant_id, state=LOCKED and o_busy are registered on that edge.
  - If no valid is set: stay IDLE, pointer unchanged.
  - o_in_ready is all-zero in IDLE.
- FSM LOCKED:
  - o_in_ready[g] = skid stage can accept; all other ready bits are 0.
  - The mux forwards port g's data/last into the skid stage.
  - When a beat with i_in_last[g]=1 is accepted: next state IDLE, pointer = (g+1) mod NUM_PORTS.
- Latency and throughput:
  - Arbitration costs one cycle: the first beat can be accepted no earlier than the cycle after the grant registers.
  - Back-to-back packets therefore have exactly one idle input cycle between them.
  - Input acceptance to o_out_valid is 1 cycle.
  - Sustained throughput within a packet is 1 beat/cycle when i_out_ready=1.
- Skid stage:
  - Two registers (output + skid).
  - Upstream ready is registered, equal to "skid register empty".
  - Never drops or duplicates beats under any ready pattern.
  - Order is preserved.
- Granted port deasserts valid mid-packet: stay LOCKED indefinitely (no timeout); other ports wait.
- Single-beat packet (valid&last on the first beat): LOCKED lasts one accepted beat.
- Non-granted ports are never acknowledged. Their held data/valid/last may change freely with no effect.
- Reset mid-packet: in-flight beats are discarded; state returns to IDLE, pointer 0, outputs at reset values the cycle after reset is sampled.
- NUM_PORTS=1: degenerates to a skid buffer with the one-cycle arbitration bubble per packet; o_grant_id is always 0.

Optional Feature:
- Macro: STREAM_RR_ARBITER_PKT_COUNT_EN.
- When defined:
  - Adds output port o_pkt_count, NUM_PORTS*16 bits.
  - Per-port counter increments when that port's last beat is accepted at the input.
  - Counter wraps 0xFFFF→0 and resets to 0.
- When undefined: the port and counters do not exist, and the remaining behaviour is identical.

Decomposition:
- Package stream_arb_pkg holds:
  - typedef arb_state_t enum {ARB_IDLE, ARB_LOCKED}.
  - Function rr_next_grant(valid vector, pointer), returning {found, index}.
  - Constant PKT_COUNT_W=16.
- Sub-module stream_skid (WIDTH+1 bits wide, carrying data+last) holds the output register pair. The arbiter top holds the FSM, pointer and mux.

Test Plan:
- Idle: all valid=0 for 100 cycles → o_out_valid never 1, o_busy=0, o_in_ready=0.
- Round-robin fairness:
  - Stimulus: ports 0..3 all continuously offer 3-beat packets, data=port*0x100+beat; i_out_ready=1.
  - Expected: output packet order 0,1,2,3,0,… with no interleaving, and exactly one bubble between packets.
- Backpressure:
  - Stimulus: port 2 sends 16 incrementing beats (last on beat 16); i_out_ready toggles 2-on/3-off, then 4-on/5-off.
  - Expected: output 0..15 in order, no loss or duplication, o_out_last only on value 15.
- Gap and skip:
  - Stimulus: port 1 drops valid for 10 cycles mid-packet while port 3 is valid.
  - Expected: port 3 is not granted until port 1's last beat is accepted; then grant=3, skipping port 2 (not valid).
- Reset mid-packet:
  - Stimulus: assert i_reset during beat 2 of a 5-beat packet.
  - Expected: next cycle o_out_valid=0 and o_grant_id=0. After release, a new packet from port 0 is granted first and delivered intact.
- Counter (macro defined): 7 packets from port 0 and 2 from port 3 → o_pkt_count fields 7,0,0,2.
